// File: rtl/core_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// core_sequencer_pkg : shared ARK core definitions (ALU ops, sequencer states)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package core_sequencer_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } seq_state_t;

  // Counter must hold the timeout value itself; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer : counts data-memory wait cycles, flags the timeout cycle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = timer_width(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      // Count is 0 in the first wait cycle, so MEM_TIMEOUT-1 marks the last allowed one.
      assign expired = (cnt_q == CW'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer : multi-cycle fetch/decode/exec/mem/wb control for ARK core
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_branch,
  input  logic             dec_halt,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             mem_req,
  output logic             mem_we,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic             retire;
  logic             timer_en;
  logic             timer_clr;
  logic             timer_expired;

  // Every non-branch, non-memory instruction writes the register file in WB,
  // so the decoder's reg-write flag carries no extra control information.
  logic unused_dec_reg_write;
  assign unused_dec_reg_write = dec_reg_write;

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    timer_en  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        ir_load = 1'b1;
        state_d = DECODE;
      end
      DECODE: state_d = dec_halt ? HALT : EXEC;
      EXEC: begin
        if (dec_branch) begin
          pc_branch = zero;
          pc_inc    = !zero;
          retire    = 1'b1;
          state_d   = FETCH;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_mem_write;
        // An ack in the expiry cycle still completes the access.
        if (mem_ack) begin
          if (dec_mem_write) begin
            pc_inc  = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timer_expired) begin
          state_d = ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        pc_inc  = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign timer_clr = (state_q != MEM) || (state_d != MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign busy    = !((state_q == IDLE) || (state_q == HALT) || (state_q == ERR));
  assign halted  = (state_q == HALT);
  assign error   = (state_q == ERR);
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer : directed vector table plus multi-cycle corner sequences
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_core_sequencer;

  // Input vector bits: {start, mem_read, mem_write, reg_write, branch, halt, zero, ack}
  localparam logic [7:0] I_START = 8'h80;
  localparam logic [7:0] I_MR    = 8'h40;
  localparam logic [7:0] I_MW    = 8'h20;
  localparam logic [7:0] I_RW    = 8'h10;
  localparam logic [7:0] I_BR    = 8'h08;
  localparam logic [7:0] I_HL    = 8'h04;
  localparam logic [7:0] I_Z     = 8'h02;
  localparam logic [7:0] I_ACK   = 8'h01;

  // Output vector bits: {ir_load, pc_inc, pc_branch, mem_req, mem_we, rf_we, busy, halted, error}
  localparam logic [8:0] O_IR  = 9'h100;
  localparam logic [8:0] O_INC = 9'h080;
  localparam logic [8:0] O_PCB = 9'h040;
  localparam logic [8:0] O_REQ = 9'h020;
  localparam logic [8:0] O_WE  = 9'h010;
  localparam logic [8:0] O_RF  = 9'h008;
  localparam logic [8:0] O_BSY = 9'h004;
  localparam logic [8:0] O_HLT = 9'h002;
  localparam logic [8:0] O_ERR = 9'h001;

  localparam int NV = 27;

  typedef struct packed {
    logic [7:0]  in;
    logic [8:0]  exp;
    logic [15:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, dmr = 1'b0, dmw = 1'b0, drw = 1'b0;
  logic dbr = 1'b0, dhl = 1'b0, zero = 1'b0, mem_ack = 1'b0;

  logic        ir_load, pc_inc, pc_branch, mem_req, mem_we, rf_we, busy, halted, error;
  logic [15:0] retired;
  logic        ir_load2, pc_inc2, pc_branch2, mem_req2, mem_we2, rf_we2, busy2, halted2, error2;
  logic [1:0]  retired2;

  always #5 clk = ~clk;

  core_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dec_mem_read(dmr), .dec_mem_write(dmw), .dec_reg_write(drw),
    .dec_branch(dbr), .dec_halt(dhl), .zero(zero), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
    .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we),
    .busy(busy), .halted(halted), .error(error), .retired(retired)
  );

  // Narrow counter, timeout disabled.
  core_sequencer #(.CNT_W(2), .MEM_TIMEOUT(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dec_mem_read(dmr), .dec_mem_write(dmw), .dec_reg_write(drw),
    .dec_branch(dbr), .dec_halt(dhl), .zero(zero), .mem_ack(mem_ack),
    .ir_load(ir_load2), .pc_inc(pc_inc2), .pc_branch(pc_branch2),
    .mem_req(mem_req2), .mem_we(mem_we2), .rf_we(rf_we2),
    .busy(busy2), .halted(halted2), .error(error2), .retired(retired2)
  );

  logic [8:0] obs;
  assign obs = {ir_load, pc_inc, pc_branch, mem_req, mem_we, rf_we, busy, halted, error};

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    {start, dmr, dmw, drw, dbr, dhl, zero, mem_ack} = v;
    #1;
  endtask

  task automatic do_reset();
    {start, dmr, dmw, drw, dbr, dhl, zero, mem_ack} = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // addi, branch taken, branch not taken, load (3 waits), store (0 waits), halt
    tbl[0]  = '{I_START,             9'h000,                   16'd0};
    tbl[1]  = '{I_RW,                O_IR | O_BSY,             16'd0};
    tbl[2]  = '{I_RW,                O_BSY,                    16'd0};
    tbl[3]  = '{I_RW,                O_BSY,                    16'd0};
    tbl[4]  = '{I_RW,                O_INC | O_RF | O_BSY,     16'd0};
    tbl[5]  = '{I_BR | I_Z,          O_IR | O_BSY,             16'd1};
    tbl[6]  = '{I_BR | I_Z,          O_BSY,                    16'd1};
    tbl[7]  = '{I_BR | I_Z,          O_PCB | O_BSY,            16'd1};
    tbl[8]  = '{I_BR,                O_IR | O_BSY,             16'd2};
    tbl[9]  = '{I_BR,                O_BSY,                    16'd2};
    tbl[10] = '{I_BR,                O_INC | O_BSY,            16'd2};
    tbl[11] = '{I_MR,                O_IR | O_BSY,             16'd3};
    tbl[12] = '{I_MR,                O_BSY,                    16'd3};
    tbl[13] = '{I_MR,                O_BSY,                    16'd3};
    tbl[14] = '{I_MR,                O_REQ | O_BSY,            16'd3};
    tbl[15] = '{I_MR,                O_REQ | O_BSY,            16'd3};
    tbl[16] = '{I_MR,                O_REQ | O_BSY,            16'd3};
    tbl[17] = '{I_MR | I_ACK,        O_REQ | O_BSY,            16'd3};
    tbl[18] = '{I_MR,                O_INC | O_RF | O_BSY,     16'd3};
    tbl[19] = '{I_MW,                O_IR | O_BSY,             16'd4};
    tbl[20] = '{I_MW,                O_BSY,                    16'd4};
    tbl[21] = '{I_MW | I_Z,          O_BSY,                    16'd4};
    tbl[22] = '{I_MW | I_ACK,        O_REQ | O_WE | O_INC | O_BSY, 16'd4};
    tbl[23] = '{I_HL | I_MR | I_ACK, O_IR | O_BSY,             16'd5};
    tbl[24] = '{I_HL | I_MR,         O_BSY,                    16'd5};
    tbl[25] = '{I_HL | I_MR | I_START, O_HLT,                  16'd5};
    tbl[26] = '{I_START,             O_HLT,                    16'd5};

    #1;
    chk("reset_outputs", {obs, retired}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].in);
      chk($sformatf("vec%0d", i), {obs, retired}, {tbl[i].exp, tbl[i].ret});
    end

    // Store with no ack: 15 MEM cycles then ERR.
    do_reset();
    drive(I_START);
    drive(I_MW);
    drive(I_MW);
    drive(I_MW);
    for (int k = 1; k <= 15; k++) begin
      drive(I_MW);
      chk($sformatf("timeout_mem%0d", k), {obs, retired}, {O_REQ | O_WE | O_BSY, 16'd0});
    end
    drive(I_MW | I_START);
    chk("timeout_err", {obs, retired}, {O_ERR, 16'd0});
    chk("timeout_disabled_still_req", {31'd0, mem_req2}, 32'd1);
    drive(I_START | I_ACK);
    chk("err_sticky", {obs, retired}, {O_ERR, 16'd0});

    // Store acked in the 15th MEM cycle completes normally.
    do_reset();
    drive(I_START);
    drive(I_MW);
    drive(I_MW);
    drive(I_MW);
    for (int k = 1; k <= 14; k++) drive(I_MW);
    drive(I_MW | I_ACK);
    chk("late_ack_mem", {obs, retired}, {O_REQ | O_WE | O_INC | O_BSY, 16'd0});
    drive(8'h00);
    chk("late_ack_fetch", {obs, retired}, {O_IR | O_BSY, 16'd1});

    // Five addi: wide counter reaches 5, 2-bit counter saturates at 3.
    do_reset();
    drive(I_START);
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 4; c++) drive(I_RW);
    end
    drive(8'h00);
    chk("retired_wide_5", {16'd0, retired}, 32'd5);
    chk("retired_sat_3", {30'd0, retired2}, 32'd3);

    // Asynchronous reset in the middle of a load's MEM cycle.
    drive(I_MR);
    drive(I_MR);
    drive(I_MR);
    chk("pre_reset_mem", {obs, retired}, {O_REQ | O_BSY, 16'd5});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {obs, retired}, 32'h0);
    chk("async_reset_sat", {29'd0, mem_req2, retired2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(I_MR | I_ACK);
    chk("post_reset_idle", {obs, retired}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
